// File: rtl/mbf.sv
// Multi-band filter: a built-in triangle-plus-square test generator drives parallel 3-tap
// low-pass and high-pass FIR filters, emitting NOut samples per stream after reset.
module mbf #(
  parameter int unsigned NOut = 527
) (
  input  logic       clk,
  input  logic       reset,
  output logic       y_valid,
  output logic       z_valid,
  output logic [7:0] y,
  output logic [7:0] z
);

  localparam logic [9:0] LastN = 10'(NOut + 1);

  typedef enum logic [1:0] {StIdle, StFill, StRun, StDone} state_e;

  state_e      state_q, state_d;
  logic [9:0]  n_q, n_d;
  logic [7:0]  tap1_q, tap1_d;
  logic [7:0]  tap2_q, tap2_d;
  logic        valid_q, valid_d;
  logic [7:0]  y_q, y_d;
  logic [7:0]  z_q, z_d;

  // Generator: x[n] = triangle(n mod 64) + 64 * n[2]
  logic [5:0]  t;
  logic [6:0]  mirr;
  logic [7:0]  tri_v;
  logic [7:0]  x_cur;

  always_comb begin
    t     = n_q[5:0];
    mirr  = 7'd64 - {1'b0, t};
    tri_v = t[5] ? 8'({mirr, 2'b00}) : {t[4:0], 2'b00};
    x_cur = tri_v + (n_q[2] ? 8'd64 : 8'd0);
  end

  // Filters use the freshly generated x[n] with the two registered taps.
  logic [9:0]         ysum;
  logic [7:0]         y_lp;
  logic signed [9:0]  h;
  logic signed [9:0]  hq;
  logic signed [10:0] zs;
  logic [7:0]         z_hp;

  always_comb begin
    ysum = {2'b00, x_cur} + {1'b0, tap1_q, 1'b0} + {2'b00, tap2_q} + 10'd2;
    y_lp = 8'(ysum >> 2);
    h    = $signed({2'b00, x_cur}) - $signed({1'b0, tap1_q, 1'b0}) + $signed({2'b00, tap2_q});
    hq   = h >>> 2;
    zs   = 11'sd128 + {hq[9], hq};
    if (zs < 11'sd0) begin
      z_hp = 8'd0;
    end else if (zs > 11'sd255) begin
      z_hp = 8'd255;
    end else begin
      z_hp = zs[7:0];
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      n_q     <= '0;
      tap1_q  <= '0;
      tap2_q  <= '0;
      valid_q <= 1'b0;
      y_q     <= '0;
      z_q     <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      tap1_q  <= tap1_d;
      tap2_q  <= tap2_d;
      valid_q <= valid_d;
      y_q     <= y_d;
      z_q     <= z_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  state_d = StFill;
      StFill:  if (n_q == 10'd1) state_d = StRun;
      StRun:   if (n_q == LastN) state_d = StDone;
      StDone:  state_d = StDone;
      default: state_d = StIdle;
    endcase
  end

  // Counter and delay line advance one sample per cycle until the stream is exhausted.
  always_comb begin
    n_d    = n_q;
    tap1_d = tap1_q;
    tap2_d = tap2_q;
    if (state_q != StDone) begin
      tap1_d = x_cur;
      tap2_d = tap1_q;
      if (n_q != LastN) begin
        n_d = n_q + 10'd1;
      end
    end
  end

  // Output logic
  always_comb begin
    valid_d = 1'b0;
    y_d     = '0;
    z_d     = '0;
    if (state_q == StRun) begin
      valid_d = 1'b1;
      y_d     = y_lp;
      z_d     = z_hp;
    end
  end

  assign y_valid = valid_q;
  assign z_valid = valid_q;
  assign y       = y_q;
  assign z       = z_q;

endmodule

// File: tb/tb_mbf.sv
// Directed bench for mbf: reset behaviour, first samples, stream length, tail, reset restart.
module tb_mbf;

  logic       clk;
  logic       reset;
  logic       y_valid;
  logic       z_valid;
  logic [7:0] y;
  logic [7:0] z;

  int n_vec;
  int n_err;

  mbf dut (
    .clk     (clk),
    .reset   (reset),
    .y_valid (y_valid),
    .z_valid (z_valid),
    .y       (y),
    .z       (z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int gen_x(input int n);
    int t;
    int tri_v;
    t = n % 64;
    tri_v = (t < 32) ? 4 * t : 4 * (64 - t);
    return tri_v + ((((n / 4) % 2) == 1) ? 64 : 0);
  endfunction

  function automatic int exp_y(input int k);
    int n;
    n = k + 2;
    return (gen_x(n) + 2 * gen_x(n - 1) + gen_x(n - 2) + 2) / 4;
  endfunction

  function automatic int exp_z(input int k);
    int n;
    int h;
    int r;
    n = k + 2;
    h = gen_x(n) - 2 * gen_x(n - 1) + gen_x(n - 2);
    r = 128 + (h >>> 2);
    if (r < 0) r = 0;
    if (r > 255) r = 255;
    return r;
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_yv"}, int'(y_valid), 0);
    check({tag, "_zv"}, int'(z_valid), 0);
    check({tag, "_y"}, int'(y), 0);
    check({tag, "_z"}, int'(z), 0);
  endtask

  task automatic check_sample(input int k);
    check("valid_y", int'(y_valid), 1);
    check("valid_eq", int'(z_valid), int'(y_valid));
    check("no_x", int'($isunknown({y, z})), 0);
    check("y_model", int'(y), exp_y(k));
    check("z_model", int'(z), exp_z(k));
    check("y_range", int'(y <= 8'd192), 1);
    check("z_range", int'(z >= 8'd32 && z <= 8'd224), 1);
  endtask

  int first_y[4] = '{8'h04, 8'h08, 8'h1C, 8'h40};
  int first_z[4] = '{8'h80, 8'h80, 8'h90, 8'h70};

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;

    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      check_idle("reset_hold");
    end

    // Edge 1 is the next rising edge; samples appear after edge 3.
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_idle("fill");
    end
    for (int k = 0; k < 527; k++) begin
      @(negedge clk);
      check_sample(k);
      if (k < 4) begin
        check("first_y", int'(y), first_y[k]);
        check("first_z", int'(z), first_z[k]);
      end
      if (k == 526) begin
        check("last_y", int'(y), 8'h6C);
        check("last_z", int'(z), 8'h70);
      end
    end
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check_idle("done");
    end

    // Restart, then pulse reset while sample 200 is on the outputs.
    reset = 1'b1;
    @(negedge clk);
    check_idle("rst2");
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_idle("fill2");
    end
    for (int k = 0; k <= 200; k++) begin
      @(negedge clk);
      check_sample(k);
    end
    reset = 1'b1;
    @(negedge clk);
    check_idle("pulse");
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_idle("fill3");
    end
    @(negedge clk);
    check_sample(0);
    check("restart_y", int'(y), 8'h04);
    check("restart_z", int'(z), 8'h80);
    @(negedge clk);
    check_sample(1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
